rob_multiport: RTL and testbench

- Parametrised reorder buffer; next generation of the 3-wide, 32-entry ROB.
- Dispatch width, retire width, completion port count and depth are generic.
- Occupancy is an explicit counter, so there is no head==tail ambiguity.
- Adds store-credit-limited retire, retire-time mispredict recovery with redirect PC, and an external flush.
- Sits between dispatch/rename (tail side), the functional-unit CDB (complete ports) and the retire/store-queue/arch-map logic (head side).

---
 rtl/rob_multiport_pkg.sv | 18 +
 rtl/rob_multiport_retire_select.sv | 40 ++++
 rtl/rob_multiport.sv | 151 +++++++++++++++
 tb/tb_rob_multiport.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_multiport_pkg.sv
// Shared definitions for the reorder buffer.
// XLEN             : architectural PC / data width
// ROB_ENTRY_PACKET : one ROB slot as written by dispatch and read by retire
package rob_multiport_pkg;

  localparam int XLEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      arch_rd;
    logic [6:0]      phys_rd;
    logic            is_store;
    logic            completed;
    logic            precise_state_need;
    logic [XLEN-1:0] target_pc;
  } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_multiport_retire_select.sv
// Retire lane selection for the reorder buffer head window.
// Ports:
//   completed_i    : candidate j is valid and completed
//   is_store_i     : candidate j is a store
//   psn_i          : candidate j needs precise-state recovery
//   store_credit_i : stores the store queue accepts this cycle
//   ret_valid_o    : contiguous prefix of retiring lanes
//   recover_lane_o : one-hot, set on the retiring lane that triggers recovery
module rob_retire_select #(
  parameter  int RW  = 3,
  localparam int CRW = $clog2(RW+1)
) (
  input  logic [RW-1:0]  completed_i,
  input  logic [RW-1:0]  is_store_i,
  input  logic [RW-1:0]  psn_i,
  input  logic [CRW-1:0] store_credit_i,
  output logic [RW-1:0]  ret_valid_o,
  output logic [RW-1:0]  recover_lane_o
);

  // Walk oldest to youngest; 'go' drops permanently at the first blocker, so
  // the result is always a prefix. A recovering lane retires but stops the
  // walk, which makes it the last retired lane.
  always_comb begin
    logic           go;
    logic [CRW-1:0] st;
    go             = 1'b1;
    st             = '0;
    ret_valid_o    = '0;
    recover_lane_o = '0;
    for (int j = 0; j < RW; j++) begin
      st                = st + {{(CRW-1){1'b0}}, is_store_i[j]};
      go                = go & completed_i[j] & (st <= store_credit_i);
      ret_valid_o[j]    = go;
      recover_lane_o[j] = go & psn_i[j];
      go                = go & ~psn_i[j];
    end
  end

endmodule

// File: rtl/rob_multiport.sv
// Parametrised multi-port reorder buffer.
// Tail side : disp_valid_i/disp_pkt_i in, disp_ready_o/disp_index_o out.
// CDB side  : cmp_valid_i/cmp_index_i/cmp_mispred_i/cmp_target_i.
// Head side : store_credit_i in; ret_valid_o/ret_pkt_o, recover_en_o/recover_pc_o out.
// Status    : count_o, empty_o, full_o.
// flush_i and a retiring mispredict both return the ROB to its reset state.
module rob_multiport
  import rob_multiport_pkg::*;
#(
  parameter  int DEPTH = 32,
  parameter  int DW    = 3,
  parameter  int RW    = 3,
  parameter  int CW    = 3,
  localparam int IDX   = $clog2(DEPTH),
  localparam int SCW   = $clog2(RW+1)
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      flush_i,
  input  logic [DW-1:0]             disp_valid_i,
  input  ROB_ENTRY_PACKET [DW-1:0]  disp_pkt_i,
  output logic [DW-1:0]             disp_ready_o,
  output logic [DW-1:0][IDX-1:0]    disp_index_o,
  input  logic [CW-1:0]             cmp_valid_i,
  input  logic [CW-1:0][IDX-1:0]    cmp_index_i,
  input  logic [CW-1:0]             cmp_mispred_i,
  input  logic [CW-1:0][XLEN-1:0]   cmp_target_i,
  input  logic [SCW-1:0]            store_credit_i,
  output logic [RW-1:0]             ret_valid_o,
  output ROB_ENTRY_PACKET [RW-1:0]  ret_pkt_o,
  output logic                      recover_en_o,
  output logic [XLEN-1:0]           recover_pc_o,
  output logic [IDX:0]              count_o,
  output logic                      empty_o,
  output logic                      full_o
);

  localparam logic [IDX:0] DEPTH_C = DEPTH[IDX:0];

  ROB_ENTRY_PACKET entries_q [DEPTH];
  ROB_ENTRY_PACKET entries_d [DEPTH];
  logic [IDX-1:0]  head_q, head_d, tail_q, tail_d;
  logic [IDX:0]    count_q, count_d;

  logic [IDX:0]    free;
  logic [DW-1:0]   disp_acc;
  logic [IDX:0]    n_acc, n_ret;
  logic [RW-1:0]   cand_cmp, cand_st, cand_psn, recover_lane;
  logic            cmp_dup;

  // Readiness uses registered occupancy only; same-cycle retires are not credited.
  assign free = DEPTH_C - count_q;

  for (genvar i = 0; i < DW; i++) begin : g_disp
    assign disp_ready_o[i] = int'(free) > i;
    assign disp_index_o[i] = tail_q + IDX'(i);
  end

  assign disp_acc = disp_valid_i & disp_ready_o;

  // Retire window: candidates beyond the occupancy are masked as not completed.
  for (genvar j = 0; j < RW; j++) begin : g_cand
    assign ret_pkt_o[j] = entries_q[head_q + IDX'(j)];
    assign cand_cmp[j]  = ret_pkt_o[j].completed & (int'(count_q) > j);
    assign cand_st[j]   = ret_pkt_o[j].is_store;
    assign cand_psn[j]  = ret_pkt_o[j].precise_state_need;
  end

  rob_retire_select #(.RW(RW)) u_sel (
    .completed_i    (cand_cmp),
    .is_store_i     (cand_st),
    .psn_i          (cand_psn),
    .store_credit_i (store_credit_i),
    .ret_valid_o    (ret_valid_o),
    .recover_lane_o (recover_lane)
  );

  assign recover_en_o = |recover_lane;

  always_comb begin
    recover_pc_o = '0;
    for (int j = 0; j < RW; j++)
      recover_pc_o = recover_pc_o | ({XLEN{recover_lane[j]}} & ret_pkt_o[j].target_pc);
  end

  always_comb begin
    n_acc = '0;
    for (int i = 0; i < DW; i++) n_acc = n_acc + {{IDX{1'b0}}, disp_acc[i]};
    n_ret = '0;
    for (int j = 0; j < RW; j++) n_ret = n_ret + {{IDX{1'b0}}, ret_valid_o[j]};
  end

  // Next state: completions, then dispatch writes, then retire clears. The
  // three touch disjoint slots for legal traffic; the retire clear wins otherwise.
  always_comb begin
    logic [IDX-1:0] off;
    entries_d = entries_q;
    head_d    = head_q + n_ret[IDX-1:0];
    tail_d    = tail_q + n_acc[IDX-1:0];
    count_d   = count_q + n_acc - n_ret;
    off       = '0;
    for (int c = 0; c < CW; c++) begin
      off = cmp_index_i[c] - head_q;
      if (cmp_valid_i[c] && ({1'b0, off} < count_q)) begin
        entries_d[cmp_index_i[c]].completed          = 1'b1;
        entries_d[cmp_index_i[c]].precise_state_need = cmp_mispred_i[c];
        entries_d[cmp_index_i[c]].target_pc          = cmp_mispred_i[c] ? cmp_target_i[c] : '0;
      end
    end
    for (int i = 0; i < DW; i++) begin
      if (disp_acc[i]) begin
        entries_d[tail_q + IDX'(i)]           = disp_pkt_i[i];
        entries_d[tail_q + IDX'(i)].completed = 1'b0;
      end
    end
    for (int j = 0; j < RW; j++)
      if (ret_valid_o[j]) entries_d[head_q + IDX'(j)] = '0;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i || flush_i || recover_en_o) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int k = 0; k < DEPTH; k++) entries_q[k] <= '0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      entries_q <= entries_d;
    end
  end

  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == DEPTH_C);

  always_comb begin
    cmp_dup = 1'b0;
    for (int a = 0; a < CW; a++)
      for (int b = a + 1; b < CW; b++)
        if (cmp_valid_i[a] && cmp_valid_i[b] && (cmp_index_i[a] == cmp_index_i[b]))
          cmp_dup = 1'b1;
  end

  // Dispatch lanes must form a contiguous prefix (x & (x+1) == 0).
  a_disp_prefix: assert property (@(posedge clock_i) disable iff (reset_i)
    (disp_valid_i & (disp_valid_i + 1'b1)) == '0);
  a_cmp_unique: assert property (@(posedge clock_i) disable iff (reset_i) !cmp_dup);

endmodule

// File: tb/tb_rob_multiport.sv
module tb_rob_multiport;
  import rob_multiport_pkg::*;

  localparam int DEPTH = 8, DW = 3, RW = 3, CW = 3, IDX = 3;

  logic                     clock = 1'b0;
  logic                     reset, flush;
  logic [DW-1:0]            disp_valid;
  ROB_ENTRY_PACKET [DW-1:0] disp_pkt;
  logic [DW-1:0]            disp_ready;
  logic [DW-1:0][IDX-1:0]   disp_index;
  logic [CW-1:0]            cmp_valid;
  logic [CW-1:0][IDX-1:0]   cmp_index;
  logic [CW-1:0]            cmp_mispred;
  logic [CW-1:0][XLEN-1:0]  cmp_target;
  logic [1:0]               store_credit;
  logic [RW-1:0]            ret_valid;
  ROB_ENTRY_PACKET [RW-1:0] ret_pkt;
  logic                     recover_en;
  logic [XLEN-1:0]          recover_pc;
  logic [IDX:0]             count;
  logic                     empty, full;

  int errors = 0, checks = 0;

  always #5 clock = ~clock;

  rob_multiport #(.DEPTH(DEPTH), .DW(DW), .RW(RW), .CW(CW)) dut (
    .clock_i(clock), .reset_i(reset), .flush_i(flush),
    .disp_valid_i(disp_valid), .disp_pkt_i(disp_pkt),
    .disp_ready_o(disp_ready), .disp_index_o(disp_index),
    .cmp_valid_i(cmp_valid), .cmp_index_i(cmp_index),
    .cmp_mispred_i(cmp_mispred), .cmp_target_i(cmp_target),
    .store_credit_i(store_credit),
    .ret_valid_o(ret_valid), .ret_pkt_o(ret_pkt),
    .recover_en_o(recover_en), .recover_pc_o(recover_pc),
    .count_o(count), .empty_o(empty), .full_o(full)
  );

  // reference model: plain circular arrays indexed by slot number
  int          m_head, m_count;
  bit          m_cmp [DEPTH];
  bit          m_st  [DEPTH];
  bit          m_psn [DEPTH];
  logic [31:0] m_tgt [DEPTH];
  logic [31:0] m_pc  [DEPTH];

  task automatic clr_in();
    flush = 1'b0; disp_valid = '0; disp_pkt = '0;
    cmp_valid = '0; cmp_index = '0; cmp_mispred = '0; cmp_target = '0;
    store_credit = '0;
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; clr_in(); tick(); reset = 1'b0;
  endtask

  task automatic disp_n(input int n, input logic [31:0] base, input logic [2:0] stm);
    for (int i = 0; i < DW; i++) begin
      disp_valid[i]         = (i < n);
      disp_pkt[i]           = '0;
      disp_pkt[i].pc        = base + 32'(i);
      disp_pkt[i].is_store  = stm[i];
      disp_pkt[i].arch_rd   = 5'(i + 1);
    end
  endtask

  task automatic cmp_set(input int p, input int idx, input bit mis, input logic [31:0] tgt);
    cmp_valid[p] = 1'b1; cmp_index[p] = IDX'(idx);
    cmp_mispred[p] = mis; cmp_target[p] = tgt;
  endtask

  task automatic test_reset();
    reset = 1'b1; clr_in(); tick(); tick(); reset = 1'b0; #1;
    checks++; if (disp_ready !== 3'b111) begin errors++; $display("FAIL reset_ready got=%b exp=111", disp_ready); end
    checks++; if (ret_valid !== 3'b000) begin errors++; $display("FAIL reset_ret got=%b exp=000", ret_valid); end
    checks++; if (recover_en !== 1'b0) begin errors++; $display("FAIL reset_recover got=%b exp=0", recover_en); end
    checks++; if ({empty, full, count} !== {1'b1, 1'b0, 4'd0}) begin errors++; $display("FAIL reset_status got=%b%b %0d exp=10 0", empty, full, count); end
    checks++; if (disp_index !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL reset_index got=%h exp=%h", disp_index, {3'd2, 3'd1, 3'd0}); end
  endtask

  task automatic test_fill();
    clr_in(); store_credit = 2'd3; disp_n(3, 32'h100, 3'b000); #1;
    checks++; if (disp_index !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL fill_idx0 got=%h", disp_index); end
    tick();
    clr_in(); store_credit = 2'd3; disp_n(3, 32'h103, 3'b000); #1;
    checks++; if (disp_index !== {3'd5, 3'd4, 3'd3}) begin errors++; $display("FAIL fill_idx1 got=%h", disp_index); end
    checks++; if (count !== 4'd3) begin errors++; $display("FAIL fill_count3 got=%0d exp=3", count); end
    tick();
    clr_in(); store_credit = 2'd3; disp_n(3, 32'h106, 3'b000); #1;
    checks++; if (disp_ready !== 3'b011) begin errors++; $display("FAIL fill_ready2 got=%b exp=011", disp_ready); end
    checks++; if (disp_index !== {3'd0, 3'd7, 3'd6}) begin errors++; $display("FAIL fill_idx2 got=%h", disp_index); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if ({full, count} !== {1'b1, 4'd8}) begin errors++; $display("FAIL fill_full got=%b %0d exp=1 8", full, count); end
    checks++; if (disp_ready !== 3'b000) begin errors++; $display("FAIL fill_ready0 got=%b exp=000", disp_ready); end
    checks++; if (ret_valid !== 3'b000) begin errors++; $display("FAIL fill_noret got=%b exp=000", ret_valid); end
  endtask

  task automatic test_complete();
    clr_in(); store_credit = 2'd3;
    cmp_set(0, 1, 1'b0, 32'hDEAD); cmp_set(1, 2, 1'b0, 32'hDEAD); #1;
    tick();
    clr_in(); store_credit = 2'd3; cmp_set(0, 0, 1'b0, 32'hBEEF); #1;
    checks++; if (ret_valid !== 3'b000) begin errors++; $display("FAIL cmp_wait0 got=%b exp=000", ret_valid); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if (ret_valid !== 3'b111) begin errors++; $display("FAIL cmp_ret3 got=%b exp=111", ret_valid); end
    checks++; if ({ret_pkt[2].pc, ret_pkt[1].pc, ret_pkt[0].pc} !== {32'h102, 32'h101, 32'h100})
      begin errors++; $display("FAIL cmp_ret_pc got=%h %h %h exp=102 101 100", ret_pkt[2].pc, ret_pkt[1].pc, ret_pkt[0].pc); end
    checks++; if (ret_pkt[1].target_pc !== 32'h0) begin errors++; $display("FAIL cmp_tgt_zero got=%h exp=0", ret_pkt[1].target_pc); end
    checks++; if (recover_en !== 1'b0) begin errors++; $display("FAIL cmp_norec got=%b exp=0", recover_en); end
    tick();
    clr_in(); store_credit = 2'd3; cmp_set(0, 3, 1'b0, 32'h0); #1;
    checks++; if ({count, disp_ready} !== {4'd5, 3'b111}) begin errors++; $display("FAIL cmp_after got=%0d %b exp=5 111", count, disp_ready); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if (ret_valid !== 3'b001 || ret_pkt[0].pc !== 32'h103)
      begin errors++; $display("FAIL cmp_head3 got=%b %h exp=001 103", ret_valid, ret_pkt[0].pc); end
    tick();
    checks++; if (count !== 4'd4) begin errors++; $display("FAIL cmp_count4 got=%0d exp=4", count); end
  endtask

  task automatic test_store_credit();
    do_reset();
    clr_in(); disp_n(3, 32'h200, 3'b101); tick();
    clr_in(); cmp_set(0, 0, 1'b0, 0); cmp_set(1, 1, 1'b0, 0); cmp_set(2, 2, 1'b0, 0); tick();
    clr_in(); store_credit = 2'd1; #1;
    checks++; if (ret_valid !== 3'b011) begin errors++; $display("FAIL st_credit1 got=%b exp=011", ret_valid); end
    tick();
    clr_in(); store_credit = 2'd0; #1;
    checks++; if (ret_valid !== 3'b000) begin errors++; $display("FAIL st_credit0 got=%b exp=000", ret_valid); end
    store_credit = 2'd1; #1;
    checks++; if (ret_valid !== 3'b001 || ret_pkt[0].pc !== 32'h202)
      begin errors++; $display("FAIL st_second got=%b %h exp=001 202", ret_valid, ret_pkt[0].pc); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL st_empty got=%b exp=1", empty); end
  endtask

  task automatic test_mispredict();
    do_reset();
    clr_in(); disp_n(3, 32'h300, 3'b000); tick();
    clr_in(); cmp_set(0, 0, 1'b0, 0); cmp_set(1, 1, 1'b1, 32'h1040); cmp_set(2, 2, 1'b0, 32'h5555); tick();
    clr_in(); store_credit = 2'd3; disp_n(3, 32'h310, 3'b000); #1;
    checks++; if (ret_valid !== 3'b011) begin errors++; $display("FAIL mp_ret got=%b exp=011", ret_valid); end
    checks++; if (recover_en !== 1'b1 || recover_pc !== 32'h1040)
      begin errors++; $display("FAIL mp_recover got=%b %h exp=1 1040", recover_en, recover_pc); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if ({empty, count} !== {1'b1, 4'd0}) begin errors++; $display("FAIL mp_empty got=%b %0d exp=1 0", empty, count); end
    checks++; if (disp_index !== {3'd2, 3'd1, 3'd0}) begin errors++; $display("FAIL mp_tail got=%h", disp_index); end
    checks++; if (ret_pkt !== '0) begin errors++; $display("FAIL mp_cleared got=%h exp=0", ret_pkt); end
  endtask

  task automatic test_wrap();
    do_reset();
    clr_in(); disp_n(3, 32'h400, 3'b000); tick();
    clr_in(); cmp_set(0, 0, 1'b0, 0); cmp_set(1, 1, 1'b0, 0); cmp_set(2, 2, 1'b0, 0); tick();
    clr_in(); store_credit = 2'd3; tick();
    clr_in(); disp_n(2, 32'h403, 3'b000); tick();
    clr_in(); cmp_set(0, 3, 1'b0, 0); cmp_set(1, 4, 1'b0, 0); tick();
    clr_in(); store_credit = 2'd3; tick();
    clr_in(); disp_n(1, 32'h405, 3'b000); tick();
    clr_in(); cmp_set(0, 5, 1'b0, 0); tick();
    clr_in(); store_credit = 2'd3; disp_n(3, 32'h406, 3'b000); #1;
    checks++; if (disp_index !== {3'd0, 3'd7, 3'd6}) begin errors++; $display("FAIL wrap_idx got=%h", disp_index); end
    checks++; if (ret_valid !== 3'b001 || ret_pkt[0].pc !== 32'h405)
      begin errors++; $display("FAIL wrap_ret1 got=%b %h exp=001 405", ret_valid, ret_pkt[0].pc); end
    tick();
    clr_in(); store_credit = 2'd3; cmp_set(0, 6, 1'b0, 0); cmp_set(1, 7, 1'b0, 0); cmp_set(2, 0, 1'b0, 0); #1;
    checks++; if (count !== 4'd3 || disp_index !== {3'd3, 3'd2, 3'd1})
      begin errors++; $display("FAIL wrap_tail got=%0d %h exp=3 tail1", count, disp_index); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if (ret_valid !== 3'b111 || {ret_pkt[2].pc, ret_pkt[1].pc, ret_pkt[0].pc} !== {32'h408, 32'h407, 32'h406})
      begin errors++; $display("FAIL wrap_ret3 got=%b %h %h %h", ret_valid, ret_pkt[2].pc, ret_pkt[1].pc, ret_pkt[0].pc); end
    tick();
    checks++; if (empty !== 1'b1) begin errors++; $display("FAIL wrap_empty got=%b exp=1", empty); end
  endtask

  task automatic test_flush();
    do_reset();
    clr_in(); disp_n(3, 32'h500, 3'b000); tick();
    clr_in(); disp_n(2, 32'h503, 3'b000); tick();
    clr_in(); flush = 1'b1; store_credit = 2'd3; cmp_set(0, 1, 1'b1, 32'h77); disp_n(3, 32'h510, 3'b000); #1;
    checks++; if (count !== 4'd5) begin errors++; $display("FAIL fl_pre got=%0d exp=5", count); end
    tick();
    clr_in(); store_credit = 2'd3; cmp_set(0, 1, 1'b1, 32'hABC); #1;
    checks++; if ({count, disp_ready, empty} !== {4'd0, 3'b111, 1'b1})
      begin errors++; $display("FAIL fl_state got=%0d %b %b exp=0 111 1", count, disp_ready, empty); end
    tick();
    clr_in(); store_credit = 2'd3; #1;
    checks++; if (ret_pkt !== '0 || ret_valid !== 3'b000 || count !== 4'd0)
      begin errors++; $display("FAIL fl_stale_cmp got=%h %b %0d exp=0", ret_pkt, ret_valid, count); end
  endtask

  task automatic test_random();
    int n, acc, nret, stc, s, off, idx;
    bit rec;
    logic [31:0] rpc;
    logic [2:0] st;
    logic [DW-1:0][IDX-1:0] e_idx;
    logic [DW-1:0] e_rdy;
    bit used [DEPTH];
    do_reset();
    m_head = 0; m_count = 0;
    for (int k = 0; k < DEPTH; k++) begin m_cmp[k] = 0; m_st[k] = 0; m_psn[k] = 0; m_tgt[k] = 0; m_pc[k] = 0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      clr_in();
      flush = ($urandom % 40) == 0;
      n = $urandom_range(0, 3); st = 3'($urandom);
      for (int i = 0; i < DW; i++) begin
        disp_valid[i] = (i < n);
        disp_pkt[i] = '0;
        disp_pkt[i].pc = $urandom;
        disp_pkt[i].is_store = st[i];
        disp_pkt[i].phys_rd = 7'($urandom);
      end
      store_credit = 2'($urandom_range(0, 3));
      for (int k = 0; k < DEPTH; k++) used[k] = 0;
      for (int p = 0; p < CW; p++) begin
        if ($urandom % 2 == 0) continue;
        if (m_count > 0 && ($urandom % 4) != 0) idx = (m_head + int'($urandom % 32'(m_count))) % DEPTH;
        else idx = $urandom_range(0, DEPTH - 1);
        if (used[idx]) continue;
        used[idx] = 1;
        cmp_set(p, idx, ($urandom % 8) == 0, $urandom);
      end
      #1;
      // expected outputs from the occupancy rules
      for (int i = 0; i < DW; i++) begin
        e_rdy[i] = (DEPTH - m_count) > i;
        e_idx[i] = IDX'((m_head + m_count + i) % DEPTH);
      end
      nret = 0; stc = 0; rec = 0; rpc = 0;
      for (int j = 0; j < RW && j < m_count; j++) begin
        s = (m_head + j) % DEPTH;
        if (!m_cmp[s]) break;
        if (m_st[s]) stc++;
        if (stc > int'(store_credit)) break;
        nret++;
        if (m_psn[s]) begin rec = 1; rpc = m_tgt[s]; break; end
      end
      checks++; if (disp_ready !== e_rdy) begin errors++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, disp_ready, e_rdy); end
      checks++; if (disp_index !== e_idx) begin errors++; $display("FAIL rnd_index cyc=%0d got=%h exp=%h", cyc, disp_index, e_idx); end
      checks++; if (ret_valid !== 3'((1 << nret) - 1)) begin errors++; $display("FAIL rnd_ret cyc=%0d got=%b exp=%0d lanes", cyc, ret_valid, nret); end
      checks++; if (recover_en !== rec) begin errors++; $display("FAIL rnd_rec cyc=%0d got=%b exp=%b", cyc, recover_en, rec); end
      if (rec) begin
        checks++; if (recover_pc !== rpc) begin errors++; $display("FAIL rnd_rpc cyc=%0d got=%h exp=%h", cyc, recover_pc, rpc); end
      end
      for (int j = 0; j < nret; j++) begin
        checks++; if (ret_pkt[j].pc !== m_pc[(m_head + j) % DEPTH])
          begin errors++; $display("FAIL rnd_rpkt cyc=%0d lane=%0d got=%h exp=%h", cyc, j, ret_pkt[j].pc, m_pc[(m_head + j) % DEPTH]); end
      end
      checks++; if ({count, empty, full} !== {4'(m_count), m_count == 0, m_count == DEPTH})
        begin errors++; $display("FAIL rnd_count cyc=%0d got=%0d %b%b exp=%0d", cyc, count, empty, full, m_count); end
      // advance the model
      if (flush || rec) begin
        m_head = 0; m_count = 0;
        for (int k = 0; k < DEPTH; k++) begin m_cmp[k] = 0; m_st[k] = 0; m_psn[k] = 0; m_tgt[k] = 0; m_pc[k] = 0; end
      end else begin
        for (int p = 0; p < CW; p++) begin
          if (!cmp_valid[p]) continue;
          idx = int'(cmp_index[p]);
          off = (idx - m_head + DEPTH) % DEPTH;
          if (off < m_count) begin
            m_cmp[idx] = 1; m_psn[idx] = cmp_mispred[p];
            m_tgt[idx] = cmp_mispred[p] ? cmp_target[p] : 32'h0;
          end
        end
        acc = (n < DEPTH - m_count) ? n : DEPTH - m_count;
        for (int i = 0; i < acc; i++) begin
          s = (m_head + m_count + i) % DEPTH;
          m_pc[s] = disp_pkt[i].pc; m_st[s] = disp_pkt[i].is_store;
          m_cmp[s] = 0; m_psn[s] = 0; m_tgt[s] = 0;
        end
        for (int j = 0; j < nret; j++) begin
          s = (m_head + j) % DEPTH;
          m_cmp[s] = 0; m_st[s] = 0; m_psn[s] = 0; m_tgt[s] = 0; m_pc[s] = 0;
        end
        m_head = (m_head + nret) % DEPTH;
        m_count = m_count + acc - nret;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1'b1;
    clr_in();
    test_reset();
    test_fill();
    test_complete();
    test_store_credit();
    test_mispredict();
    test_wrap();
    test_flush();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
